// File: rtl/crc_drv_pkg.sv
// Shared definitions for the APB4 CRC offload driver: register map,
// CTRL field layout, mode/size encodings and the driver state machine.
package crc_drv_pkg;

   // Register offsets inside the CRC peripheral
   localparam logic [7:0] REG_CTRL = 8'h00;
   localparam logic [7:0] REG_INIT = 8'h04;
   localparam logic [7:0] REG_XORV = 8'h08;
   localparam logic [7:0] REG_DATA = 8'h0C;
   localparam logic [7:0] REG_STAT = 8'h10;

   // CTRL register field positions
   localparam int unsigned CTRL_W          = 7;
   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_REVIN_BIT  = 1;
   localparam int unsigned CTRL_REVOUT_BIT = 2;
   localparam int unsigned CTRL_MODE_LSB   = 3;
   localparam int unsigned CTRL_SIZE_LSB   = 5;

   typedef enum logic [1:0] {
      MODE_CRC32  = 2'd0,
      MODE_CRC16  = 2'd1,
      MODE_CRC8   = 2'd2,
      MODE_CUSTOM = 2'd3
   } crc_mode_e;

   typedef enum logic [1:0] {
      SIZE_8  = 2'd0,
      SIZE_16 = 2'd1,
      SIZE_32 = 2'd2
   } crc_size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTRL,
      ST_INIT,
      ST_XORV,
      ST_WDAT,
      ST_WAIT,
      ST_RDAT,
      ST_RSP
   } drv_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_ACCESS
   } xfer_phase_e;

   // First config write still needed after 'cur'; skip[0]=CTRL, [1]=INIT, [2]=XORV.
   function automatic drv_state_e next_cfg_state(drv_state_e cur, logic [2:0] skip);
      drv_state_e n;
      n = ST_WDAT;
      if (cur == ST_IDLE && !skip[0])
         n = ST_CTRL;
      else if ((cur == ST_IDLE || cur == ST_CTRL) && !skip[1])
         n = ST_INIT;
      else if (cur != ST_XORV && !skip[2])
         n = ST_XORV;
      return n;
   endfunction

endpackage

// File: rtl/apb4_mst_xfer.sv
// Single APB4 transfer sequencer: one SETUP cycle, then ACCESS until pready.
module apb4_mst_xfer
   import crc_drv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  write_i,
   input  logic [31:0]           wdata_i,
   output logic                  done_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic                  pwrite_o,
   output logic [31:0]           pwdata_o,
   input  logic [31:0]           prdata_i,
   input  logic                  pready_i,
   input  logic                  pslverr_i
);

   xfer_phase_e           phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [31:0]           wdata_q;
   logic                  load;

   // Completion detect and phase sequencing; a start on the completing
   // ACCESS cycle chains straight into the next SETUP.
   always_comb begin
      done_o  = (phase_q == PH_ACCESS) && pready_i;
      load    = start_i && ((phase_q == PH_IDLE) || done_o);
      phase_d = phase_q;
      case (phase_q)
         PH_IDLE:   if (load) phase_d = PH_SETUP;
         PH_SETUP:  phase_d = PH_ACCESS;
         PH_ACCESS: if (done_o) phase_d = load ? PH_SETUP : PH_IDLE;
         default:   phase_d = PH_IDLE;
      endcase
   end

   // Phase register; address/direction/data held from SETUP to completion.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         phase_q <= PH_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         phase_q <= phase_d;
         if (load) begin
            addr_q  <= addr_i;
            write_q <= write_i;
            wdata_q <= wdata_i;
         end
      end
   end

   assign psel_o    = (phase_q != PH_IDLE);
   assign penable_o = (phase_q == PH_ACCESS);
   assign paddr_o   = addr_q;
   assign pwrite_o  = write_q;
   assign pwdata_o  = wdata_q;
   assign rdata_o   = prdata_i;
   assign err_o     = done_o && pslverr_i;

endmodule

// File: rtl/apb4_crc_drv.sv
// APB4 initiator running single-word CRC jobs on the apb4_crc peripheral,
// with a config cache that skips unchanged CTRL/INIT/XORV writes.
module apb4_crc_drv
   import crc_drv_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           WAIT_CYC   = 8,
   parameter bit                    CFG_CACHE  = 1'b1
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [6:0]            req_ctrl_i,
   input  logic [31:0]           req_init_i,
   input  logic [31:0]           req_xorv_i,
   input  logic [31:0]           req_data_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_crc_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [31:0]           pwdata_o,
   output logic [3:0]            pstrb_o,
   output logic [2:0]            pprot_o,
   input  logic [31:0]           prdata_i,
   input  logic                  pready_i,
   input  logic                  pslverr_i
);

   localparam int unsigned     CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

   drv_state_e            state_q, state_d;
   logic [CTRL_W-1:0]     ctrl_q, cache_ctrl_q, j_ctrl;
   logic [31:0]           init_q, xorv_q, data_q, j_init, j_xorv, j_data;
   logic [31:0]           cache_init_q, cache_xorv_q;
   logic                  cache_vld_q;
   logic [2:0]            skip_q, skip_in;
   logic [CNT_W-1:0]      cnt_q;
   logic [31:0]           rsp_crc_q;
   logic                  rsp_err_q;

   logic                  x_start, x_write, x_done, x_err;
   logic [ADDR_WIDTH-1:0] x_addr;
   logic [31:0]           x_wdata, x_rdata;

   // In IDLE the job is not yet registered, so the first transfer is built from the request port.
   assign j_ctrl = (state_q == ST_IDLE) ? req_ctrl_i : ctrl_q;
   assign j_init = (state_q == ST_IDLE) ? req_init_i : init_q;
   assign j_xorv = (state_q == ST_IDLE) ? req_xorv_i : xorv_q;
   assign j_data = (state_q == ST_IDLE) ? req_data_i : data_q;

   // Cache-hit flags and next-state selection; skipped config states cost no cycles.
   always_comb begin
      skip_in[0] = CFG_CACHE && cache_vld_q && (req_ctrl_i == cache_ctrl_q);
      skip_in[1] = CFG_CACHE && cache_vld_q && (req_init_i == cache_init_q);
      skip_in[2] = CFG_CACHE && cache_vld_q && (req_xorv_i == cache_xorv_q);
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:                   if (req_valid_i) state_d = next_cfg_state(ST_IDLE, skip_in);
         ST_CTRL, ST_INIT, ST_XORV: if (x_done) state_d = x_err ? ST_RSP : next_cfg_state(state_q, skip_q);
         ST_WDAT:                   if (x_done) state_d = x_err ? ST_RSP : ST_WAIT;
         ST_WAIT:                   if (cnt_q == CNT_LAST) state_d = ST_RDAT;
         ST_RDAT:                   if (x_done) state_d = ST_RSP;
         ST_RSP:                    if (rsp_ready_i) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // A transfer is launched on the cycle the FSM moves into a bus state.
   always_comb begin
      x_start = (state_d != state_q) &&
                (state_d inside {ST_CTRL, ST_INIT, ST_XORV, ST_WDAT, ST_RDAT});
      x_write = 1'b1;
      x_addr  = BASE_ADDR + ADDR_WIDTH'(REG_CTRL);
      x_wdata = 32'(j_ctrl);
      case (state_d)
         ST_INIT: begin
            x_addr  = BASE_ADDR + ADDR_WIDTH'(REG_INIT);
            x_wdata = j_init;
         end
         ST_XORV: begin
            x_addr  = BASE_ADDR + ADDR_WIDTH'(REG_XORV);
            x_wdata = j_xorv;
         end
         ST_WDAT: begin
            x_addr  = BASE_ADDR + ADDR_WIDTH'(REG_DATA);
            x_wdata = j_data;
         end
         ST_RDAT: begin
            x_addr  = BASE_ADDR + ADDR_WIDTH'(REG_DATA);
            x_write = 1'b0;
            x_wdata = '0;
         end
         default: ;
      endcase
   end

   // State, job capture, config cache, wait counter and response registers.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q      <= ST_IDLE;
         ctrl_q       <= '0;
         init_q       <= '0;
         xorv_q       <= '0;
         data_q       <= '0;
         skip_q       <= '0;
         cache_ctrl_q <= '0;
         cache_init_q <= '0;
         cache_xorv_q <= '0;
         cache_vld_q  <= 1'b0;
         cnt_q        <= '0;
         rsp_crc_q    <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid_i) begin
            ctrl_q    <= req_ctrl_i;
            init_q    <= req_init_i;
            xorv_q    <= req_xorv_i;
            data_q    <= req_data_i;
            skip_q    <= skip_in;
            rsp_crc_q <= '0;
            rsp_err_q <= 1'b0;
         end
         if (x_done) begin
            if (x_err) begin
               rsp_err_q   <= 1'b1;
               rsp_crc_q   <= '0;
               cache_vld_q <= 1'b0;
            end else begin
               case (state_q)
                  ST_CTRL: begin
                     cache_ctrl_q <= ctrl_q;
                     cache_vld_q  <= 1'b1;
                  end
                  ST_INIT: cache_init_q <= init_q;
                  ST_XORV: cache_xorv_q <= xorv_q;
                  ST_RDAT: rsp_crc_q    <= x_rdata;
                  default: ;
               endcase
            end
         end
         if (state_q == ST_WAIT)
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   apb4_mst_xfer #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_xfer (
      .clk_i     (pclk),
      .rst_ni    (presetn),
      .start_i   (x_start),
      .addr_i    (x_addr),
      .write_i   (x_write),
      .wdata_i   (x_wdata),
      .done_o    (x_done),
      .rdata_o   (x_rdata),
      .err_o     (x_err),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .paddr_o   (paddr_o),
      .pwrite_o  (pwrite_o),
      .pwdata_o  (pwdata_o),
      .prdata_i  (prdata_i),
      .pready_i  (pready_i),
      .pslverr_i (pslverr_i)
   );

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RSP);
   assign rsp_crc_o   = rsp_crc_q;
   assign rsp_err_o   = rsp_err_q;
   assign pstrb_o     = pwrite_o ? 4'hF : 4'h0;
   assign pprot_o     = 3'b000;

endmodule

// File: tb/tb_apb4_crc_drv.sv
// Scoreboard bench for apb4_crc_drv: a transaction-level model predicts the
// APB transfer list, result and latency of each job; monitors compare.
`timescale 1ns/1ps
module tb_apb4_crc_drv;

   localparam int unsigned AW   = 32;
   localparam logic [31:0] BASE = 32'h4000_0100;
   localparam int unsigned WC   = 8;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [6:0]  req_ctrl = '0;
   logic [31:0] req_init = '0, req_xorv = '0, req_data = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_crc;
   logic [31:0] paddr, pwdata;
   logic        psel, penable, pwrite;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;

   always #5 pclk = ~pclk;

   apb4_crc_drv #(
      .ADDR_WIDTH(AW),
      .BASE_ADDR (BASE),
      .WAIT_CYC  (WC),
      .CFG_CACHE (1'b1)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_ctrl_i  (req_ctrl),
      .req_init_i  (req_init),
      .req_xorv_i  (req_xorv),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_crc_o   (rsp_crc),
      .rsp_err_o   (rsp_err),
      .paddr_o     (paddr),
      .psel_o      (psel),
      .penable_o   (penable),
      .pwrite_o    (pwrite),
      .pwdata_o    (pwdata),
      .pstrb_o     (pstrb),
      .pprot_o     (pprot),
      .prdata_i    (prdata),
      .pready_i    (pready),
      .pslverr_i   (pslverr)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      logic [31:0] crc;
      logic        err;
      int unsigned lat;
   } rsp_t;

   xfer_t exp_x[$];
   rsp_t  exp_r[$];

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned cyc = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic void fail(string name);
      n_chk++;
      $display("FAIL %s: event did not occur as expected", name);
   endfunction

   function automatic xfer_t mk(logic [31:0] a, logic w, logic [31:0] d);
      xfer_t t;
      t.addr = a; t.wr = w; t.wdata = d;
      return t;
   endfunction

   always @(posedge pclk) cyc++;

   // ---------------- slave model ----------------
   int unsigned slv_ws = 0, acc_cnt = 0;
   logic [31:0] slv_rdata = '0, slv_err_addr = '0;
   logic        slv_err_en = 1'b0, slv_err_wr = 1'b0;

   always @(posedge pclk) begin
      #1;
      if (psel && !penable) acc_cnt = 0;
      if (psel && penable) begin
         pready = (acc_cnt == slv_ws);
         acc_cnt++;
      end else begin
         pready = 1'b0;
      end
      prdata  = pready ? slv_rdata : $urandom();
      pslverr = pready && slv_err_en && (paddr == slv_err_addr) && (pwrite == slv_err_wr);
   end

   // ---------------- reference model ----------------
   logic        m_vld = 1'b0;
   logic [6:0]  m_ctrl = '0;
   logic [31:0] m_init = '0, m_xorv = '0;

   task automatic plan_job(input logic [6:0] c, input logic [31:0] i, input logic [31:0] x,
                           input logic [31:0] d, input logic [31:0] rd, input int unsigned ws);
      xfer_t seq[$];
      rsp_t  r;
      bit    hit_c, hit_i, hit_x;
      hit_c = m_vld && (c == m_ctrl);
      hit_i = m_vld && (i == m_init);
      hit_x = m_vld && (x == m_xorv);
      if (!hit_c) seq.push_back(mk(BASE + 32'h0, 1'b1, {25'b0, c}));
      if (!hit_i) seq.push_back(mk(BASE + 32'h4, 1'b1, i));
      if (!hit_x) seq.push_back(mk(BASE + 32'h8, 1'b1, x));
      seq.push_back(mk(BASE + 32'hC, 1'b1, d));
      seq.push_back(mk(BASE + 32'hC, 1'b0, 32'h0));
      r.crc = rd; r.err = 1'b0; r.lat = 1;
      for (int k = 0; k < seq.size(); k++) begin
         exp_x.push_back(seq[k]);
         r.lat += 2 + ws;
         if (slv_err_en && seq[k].addr == slv_err_addr && seq[k].wr == slv_err_wr) begin
            r.err = 1'b1; r.crc = '0; m_vld = 1'b0;
            break;
         end
         case (seq[k].addr - BASE)
            32'h0: begin m_ctrl = c; m_vld = 1'b1; end
            32'h4: m_init = i;
            32'h8: m_xorv = x;
            32'hC: if (seq[k].wr) r.lat += WC;
            default: ;
         endcase
      end
      exp_r.push_back(r);
   endtask

   // ---------------- APB monitor ----------------
   logic [31:0] s_addr, s_wdata;
   logic        s_wr;
   xfer_t       mx;
   int unsigned wdat_cyc = 0;
   bit          wdat_seen = 0;

   always @(negedge pclk) if (presetn) begin
      if (psel && !penable) begin
         s_addr = paddr; s_wr = pwrite; s_wdata = pwdata;
         if (paddr == BASE + 32'hC && !pwrite)
            chk("wait_gap", cyc - wdat_cyc, WC + 1);
      end
      if (psel && penable) begin
         chk("paddr_stable", paddr, s_addr);
         chk("pwrite_stable", pwrite, s_wr);
         chk("pwdata_stable", pwdata, s_wdata);
         if (pready) begin
            if (exp_x.size() == 0) begin
               $display("FAIL unexpected_xfer: addr 0x%0h write %0b with none expected", paddr, pwrite);
               n_chk++;
            end else begin
               mx = exp_x.pop_front();
               chk("xfer_addr", paddr, mx.addr);
               chk("xfer_dir", pwrite, mx.wr);
               if (mx.wr) chk("xfer_wdata", pwdata, mx.wdata);
               chk("pstrb", pstrb, mx.wr ? 4'hF : 4'h0);
               chk("pprot", pprot, 3'b000);
               if (mx.wr && mx.addr == BASE + 32'hC) begin
                  wdat_cyc  = cyc;
                  wdat_seen = 1;
               end
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   int unsigned hs_cyc = 0;
   bit          rsp_seen = 0;
   rsp_t        mr;

   always @(negedge pclk) if (presetn) begin
      if (req_valid && req_ready) begin
         hs_cyc   = cyc;
         rsp_seen = 0;
      end
      if (rsp_valid) begin
         chk("req_ready_in_rsp", req_ready, 1'b0);
         if (exp_r.size() == 0) begin
            $display("FAIL spurious_rsp: crc 0x%0h err %0b with none expected", rsp_crc, rsp_err);
            n_chk++;
         end else begin
            if (!rsp_seen) begin
               rsp_seen = 1;
               chk("latency", cyc - hs_cyc, exp_r[0].lat);
            end
            chk("rsp_crc", rsp_crc, exp_r[0].crc);
            chk("rsp_err", rsp_err, exp_r[0].err);
            if (rsp_ready) mr = exp_r.pop_front();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_job(input logic [6:0] c, input logic [31:0] i, input logic [31:0] x,
                         input logic [31:0] d, input logic [31:0] rd, input int unsigned ws,
                         input int unsigned stall, input bit rst_wait);
      int unsigned t;
      slv_ws = ws; slv_rdata = rd; wdat_seen = 0;
      plan_job(c, i, x, d, rd, ws);
      req_valid = 1'b1; req_ctrl = c; req_init = i; req_xorv = x; req_data = d;
      t = 0;
      while (!req_ready && t < 100) begin @(posedge pclk); #1; t++; end
      if (t >= 100) fail("req_accept_timeout");
      @(posedge pclk); #1;
      req_valid = 1'b0; req_ctrl = 7'($urandom()); req_data = $urandom();
      if (rst_wait) begin
         t = 0;
         while (!wdat_seen && t < 300) begin @(posedge pclk); #1; t++; end
         if (t >= 300) fail("wdat_timeout");
         @(posedge pclk); #1;
         presetn = 1'b0;
         @(posedge pclk); #1;
         chk("midrst_psel", psel, 1'b0);
         chk("midrst_rsp_valid", rsp_valid, 1'b0);
         chk("midrst_req_ready", req_ready, 1'b1);
         exp_x.delete(); exp_r.delete(); m_vld = 1'b0;
         presetn = 1'b1;
      end else begin
         if (stall > 0) begin
            rsp_ready = 1'b0;
            t = 0;
            while (!rsp_valid && t < 400) begin @(posedge pclk); #1; t++; end
            if (t >= 400) fail("rsp_valid_timeout");
            repeat (stall) begin @(posedge pclk); #1; end
            rsp_ready = 1'b1;
         end
         t = 0;
         while (exp_r.size() != 0 && t < 400) begin @(posedge pclk); #1; t++; end
         if (t >= 400) fail("rsp_timeout");
         chk("xfers_left", exp_x.size(), 0);
      end
   endtask

   logic [6:0]  r_ctrl;
   logic [31:0] r_init, r_xorv;
   int unsigned k_err;

   initial begin
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_crc", rsp_crc, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      presetn = 1'b1;
      @(posedge pclk); #1;

      // full config, then cache hit
      do_job(7'h01, 32'h0, 32'h0, 32'h31, 32'h97, 0, 0, 0);
      do_job(7'h01, 32'h0, 32'h0, 32'h32, $urandom(), 0, 0, 0);
      // all config changed, three wait states per ACCESS
      do_job(7'h45, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom(), $urandom(), 3, 0, 0);
      // slave error on the INIT write, then the identical job rewrites CTRL
      slv_err_en = 1'b1; slv_err_addr = BASE + 32'h4; slv_err_wr = 1'b1;
      do_job(7'h03, 32'h1234, 32'h5678, $urandom(), $urandom(), 0, 0, 0);
      slv_err_en = 1'b0;
      do_job(7'h03, 32'h1234, 32'h5678, $urandom(), $urandom(), 0, 0, 0);
      // response back-pressure
      do_job(7'h03, 32'h1234, 32'h5678, $urandom(), $urandom(), 1, 10, 0);
      // reset during WAIT, then the next job writes all config again
      do_job(7'h2B, 32'hA5A5_0001, 32'h0, $urandom(), $urandom(), 0, 0, 1);
      do_job(7'h2B, 32'hA5A5_0001, 32'h0, $urandom(), $urandom(), 0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0: r_ctrl = 7'h01;
            1: r_ctrl = 7'h03;
            2: r_ctrl = 7'h45;
            default: r_ctrl = 7'h2B;
         endcase
         r_init = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
         r_xorv = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
         slv_err_en = 1'b0;
         if ($urandom_range(0, 5) == 0) begin
            k_err = $urandom_range(0, 4);
            slv_err_en = 1'b1;
            if (k_err == 4) begin
               slv_err_addr = BASE + 32'hC; slv_err_wr = 1'b0;
            end else begin
               slv_err_addr = BASE + 32'(4 * k_err); slv_err_wr = 1'b1;
            end
         end
         do_job(r_ctrl, r_init, r_xorv, $urandom(), $urandom(), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 0);
      end
      slv_err_en = 1'b0;

      repeat (3) @(posedge pclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/apb4_crc_drv.md
Name: apb4_crc_drv

Overview:
APB4 initiator that offloads single-word CRC jobs to the apb4_crc peripheral. It accepts a job over a valid/ready request port and programs CTRL, INIT and XORV, skipping any register whose cached value already matches. It then writes DATA, waits out the fixed computation latency, reads DATA back and returns the result on a valid/ready response port. It sits between a local engine (DMA, packet framer) and the peripheral bus as the bus-side master for the CRC block.

Parameters:
ADDR_WIDTH, 32, width of paddr_o.
BASE_ADDR, 32'h0, base address of the CRC peripheral; register offsets come from the package.
WAIT_CYC, 8, idle cycles between the DATA-write ACCESS completion and the DATA-read SETUP; 8 covers the worst case, 32-bit data.
CFG_CACHE, 1, 1 = skip CTRL/INIT/XORV writes whose value equals the cached one; 0 = always write all three.

Ports:
pclk  in  1  sole clock
presetn  in  1  synchronous active-low reset
req_valid_i  in  1  job request valid
req_ready_o  out  1  driver can accept a job
req_ctrl_i  in  7  CTRL image: [0] en, [1] revin, [2] revout, [4:3] mode, [6:5] size
req_init_i  in  32  CRC initial value
req_xorv_i  in  32  final XOR value
req_data_i  in  32  payload, right-aligned to size
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed
rsp_crc_o  out  32  DATA register read-back
rsp_err_o  out  1  pslverr seen during this job
paddr_o  out  ADDR_WIDTH  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  32  APB write data
pstrb_o  out  4  always 4'hF on writes, 4'h0 on reads
pprot_o  out  3  always 3'b000
prdata_i  in  32  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB error

Behaviour:
- Clock and reset: one clock, pclk; reset presetn is synchronous and active-low.
- Reset values:
  - state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_crc_o=0; rsp_err_o=0.
  - psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0.
  - cache-valid=0, wait counter=0.
- Reset mid-job drops the job and any open APB transfer at the next edge; no partial response is produced.
- Request capture: the job is captured into internal registers on req_valid_i&&req_ready_o. req_ready_o=1 only in IDLE.
- FSM states: IDLE -> CTRL -> INIT -> XORV -> WDAT -> WAIT -> RDAT -> RSP -> IDLE.
- Config skip: with CFG_CACHE=1 and cache-valid, CTRL/INIT/XORV are each skipped when equal to the cached copy. A skipped state costs zero cycles; the next state is computed combinationally at capture.
- APB transfer states (CTRL, INIT, XORV, WDAT, RDAT):
  - One SETUP cycle: psel=1, penable=0.
  - Then ACCESS cycles: psel=1, penable=1, held until pready_i=1.
  - paddr/pwrite/pwdata stay stable from SETUP through ACCESS completion.
  - No idle cycle between back-to-back transfers: the next SETUP follows the completing ACCESS cycle.
- WDAT writes req_data_i unmodified; bit reversal is the peripheral's job.
- Cache update: cache registers update on a write's completing ACCESS cycle when pslverr_i=0. cache-valid is set after a successful CTRL write.
- WAIT: counts WAIT_CYC cycles with psel=0, then moves to RDAT.
- RDAT: prdata_i is sampled into rsp_crc_o on the completing ACCESS cycle.
- Error path: pslverr_i=1 on any completing ACCESS cycle:
  - abort the remaining transfers and go straight to RSP;
  - rsp_err_o=1, rsp_crc_o=0;
  - clear cache-valid.
- RSP: rsp_valid_o=1 held until rsp_ready_i; IDLE is entered on the handshake cycle.
- Job overlap: a new request is accepted the cycle after the response handshake; no overlap between jobs.
- Minimum latency, full config with pready tied 1: capture to rsp_valid_o = 4 transfers×2 + WAIT_CYC + 2 (RDAT) + 1 cycles.

Decomposition:
- Package crc_drv_pkg holds:
  - register offsets CTRL=0x0, INIT=0x4, XORV=0x8, DATA=0xC, STAT=0x10;
  - CTRL bit-field positions;
  - mode/size encodings;
  - the FSM state enum.
- Sub-module apb4_mst_xfer: single-transfer SETUP/ACCESS sequencer.
  - Inputs: start, addr, write, wdata.
  - Outputs: done, rdata, err.
  - Interfaces to the FSM by start/done.

Test Plan:
1. Reset, then job ctrl=0x01, init=0, xorv=0, data=0x31; slave model returns 0x97, pready=1 -> 5 transfers in order CTRL,INIT,XORV,WDAT,RDAT; ≥8 idle cycles before RDAT SETUP; rsp_crc_o=0x00000097, rsp_err_o=0.
2. Second job with identical ctrl/init/xorv, data=0x32 -> only WDAT and RDAT appear on the bus; cache hit.
3. Slave inserts 3 wait states on every ACCESS -> paddr/pwdata stable throughout; result still correct; latency grows by 15 cycles.
4. pslverr_i=1 on the INIT write -> XORV/WDAT/RDAT never issued; rsp_err_o=1, rsp_crc_o=0; next identical job rewrites CTRL.
5. rsp_ready_i held low 10 cycles -> rsp_valid_o and rsp_crc_o stable; req_ready_o=0 until handshake.
6. presetn low during WAIT for one cycle -> psel_o=0, rsp_valid_o=0, req_ready_o=1 next cycle; next job writes all three config registers.
